// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a 128-bit line refill port.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_wb (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [3:0]   memRead,
   input  logic [2:0]   memWrite,
   input  logic [31:0]  ADDRESS,
   input  logic [31:0]  WRITE_DATA,
   output logic [31:0]  READ_DATA,
   output logic         BUSY_WAIT,
   output logic         MAIN_MEM_READ,
   output logic         MAIN_MEM_WRITE,
   output logic [27:0]  MAIN_MEM_ADDRESS,
   output logic [127:0] MAIN_MEM_WRITE_DATA,
   input  logic [127:0] MAIN_MEM_READ_DATA,
   input  logic         MAIN_MEM_BUSY_WAIT
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]  HIT_COUNT,
   output logic [31:0]  MISS_COUNT
`endif
);
   localparam int unsigned LINES      = 8;
   localparam int unsigned BLOCK_BITS = 128;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned TAG_W      = 25;
   localparam int unsigned BYTES      = BLOCK_BITS / 8;

   typedef enum logic [1:0] {IDLE, WRITEBACK, MEM_READ, UPDATE} state_t;

   state_t                state_q, state_d;
   logic                  first_q, first_d;
   logic [BLOCK_BITS-1:0] fill_q, fill_d;
   logic [BLOCK_BITS-1:0] data_q [LINES];
   logic [TAG_W-1:0]      tag_q  [LINES];
   logic [LINES-1:0]      valid_q, dirty_q;

   logic [IDX_W-1:0]      idx;
   logic [TAG_W-1:0]      tag_in;
   logic [3:0]            off;
   logic [BLOCK_BITS-1:0] line, merged, wr_data;
   logic [BYTES-1:0]      wr_mask;
   logic                  hit, req, load_req, store_req, store_fire;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           rd_word;

   assign idx       = ADDRESS[6:4];
   assign tag_in    = ADDRESS[31:7];
   assign off       = ADDRESS[3:0];
   assign line      = data_q[idx];
   assign hit       = valid_q[idx] && (tag_q[idx] == tag_in);
   assign store_req = memWrite[2];
   assign load_req  = memRead[3] && !memWrite[2];
   assign req       = memRead[3] || memWrite[2];
   assign rd_byte   = line[{off, 3'b000} +: 8];
   assign rd_half   = line[{off[3:1], 4'b0000} +: 16];
   assign rd_word   = line[{off[3:2], 5'b00000} +: 32];

   // Load extraction; only a load hit in IDLE drives non-zero data
   always_comb begin
      READ_DATA = '0;
      if (!RESET && state_q == IDLE && load_req && hit) begin
         case (memRead[2:0])
            3'b000:  READ_DATA = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  READ_DATA = {{16{rd_half[15]}}, rd_half};
            3'b010:  READ_DATA = rd_word;
            3'b100:  READ_DATA = {24'h0, rd_byte};
            3'b101:  READ_DATA = {16'h0, rd_half};
            default: READ_DATA = '0;
         endcase
      end
   end

   // Store byte enables and replicated data, merged into the indexed line
   always_comb begin
      wr_mask = '0;
      wr_data = '0;
      case (memWrite[1:0])
         2'b00: begin
            wr_mask = BYTES'(16'h0001 << off);
            wr_data = {16{WRITE_DATA[7:0]}};
         end
         2'b01: begin
            wr_mask = BYTES'(16'h0003 << {off[3:1], 1'b0});
            wr_data = {8{WRITE_DATA[15:0]}};
         end
         2'b10: begin
            wr_mask = BYTES'(16'h000F << {off[3:2], 2'b00});
            wr_data = {4{WRITE_DATA}};
         end
         default: begin
            wr_mask = '0;
            wr_data = '0;
         end
      endcase
      for (int b = 0; b < BYTES; b++)
         merged[b*8 +: 8] = wr_mask[b] ? wr_data[b*8 +: 8] : line[b*8 +: 8];
   end

   assign store_fire = !RESET && state_q == IDLE && store_req && hit && (|wr_mask);

   // Miss handling FSM: next state and main-memory handshake
   always_comb begin
      state_d             = state_q;
      first_d             = 1'b0;
      fill_d              = fill_q;
      BUSY_WAIT           = 1'b0;
      MAIN_MEM_READ       = 1'b0;
      MAIN_MEM_WRITE      = 1'b0;
      MAIN_MEM_ADDRESS    = '0;
      MAIN_MEM_WRITE_DATA = '0;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               BUSY_WAIT = 1'b1;
               state_d   = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : MEM_READ;
               first_d   = 1'b1;
            end
         end
         WRITEBACK: begin
            BUSY_WAIT           = 1'b1;
            MAIN_MEM_WRITE      = 1'b1;
            MAIN_MEM_ADDRESS    = {tag_q[idx], idx};
            MAIN_MEM_WRITE_DATA = line;
            if (!first_q && !MAIN_MEM_BUSY_WAIT) begin
               state_d = MEM_READ;
               first_d = 1'b1;
            end
         end
         MEM_READ: begin
            BUSY_WAIT        = 1'b1;
            MAIN_MEM_READ    = 1'b1;
            MAIN_MEM_ADDRESS = ADDRESS[31:4];
            if (!first_q && !MAIN_MEM_BUSY_WAIT) begin
               fill_d  = MAIN_MEM_READ_DATA;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            BUSY_WAIT = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (RESET) begin
         BUSY_WAIT           = 1'b0;
         MAIN_MEM_READ       = 1'b0;
         MAIN_MEM_WRITE      = 1'b0;
         MAIN_MEM_ADDRESS    = '0;
         MAIN_MEM_WRITE_DATA = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         first_q <= 1'b0;
         fill_q  <= '0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         fill_q  <= fill_d;
         if (state_q == UPDATE) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end else if (store_fire) begin
            dirty_q[idx] <= 1'b1;
         end
      end
   end

   // Line data and tags carry no reset; valid bits qualify them
   always_ff @(posedge CLK) begin
      if (!RESET && state_q == UPDATE) begin
         data_q[idx] <= fill_q;
         tag_q[idx]  <= tag_in;
      end else if (store_fire) begin
         data_q[idx] <= merged;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        after_fill_q;

   // The hit that ends a miss is the same access, so it is not counted again
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         after_fill_q <= 1'b0;
      end else begin
         after_fill_q <= (state_q == UPDATE);
         if (state_q == IDLE && req && hit && !after_fill_q && hit_cnt_q != 32'hFFFF_FFFF)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == IDLE && state_d != IDLE && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a flat byte-memory reference with a line shadow.
module tb_dcache_wb;
   logic         CLK = 1'b0;
   logic         RESET;
   logic [3:0]   memRead;
   logic [2:0]   memWrite;
   logic [31:0]  ADDRESS, WRITE_DATA, READ_DATA;
   logic         BUSY_WAIT, MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_BUSY_WAIT;
   logic [27:0]  MAIN_MEM_ADDRESS;
   logic [127:0] MAIN_MEM_WRITE_DATA, MAIN_MEM_READ_DATA;
`ifdef DCACHE_STATS_EN
   logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

   dcache_wb dut (
      .CLK(CLK), .RESET(RESET), .memRead(memRead), .memWrite(memWrite),
      .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
      .BUSY_WAIT(BUSY_WAIT), .MAIN_MEM_READ(MAIN_MEM_READ), .MAIN_MEM_WRITE(MAIN_MEM_WRITE),
      .MAIN_MEM_ADDRESS(MAIN_MEM_ADDRESS), .MAIN_MEM_WRITE_DATA(MAIN_MEM_WRITE_DATA),
      .MAIN_MEM_READ_DATA(MAIN_MEM_READ_DATA), .MAIN_MEM_BUSY_WAIT(MAIN_MEM_BUSY_WAIT)
`ifdef DCACHE_STATS_EN
      , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  mr;
      logic [2:0]  mw;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          st;
   } vec_t;

   int n_cmp = 0, n_bad = 0;

   // Main-memory responder state
   logic [127:0] mm [logic [27:0]];
   int           stretch = 0, kind_cnt = 0;
   logic [1:0]   prev_kind = 2'b00;
   int           rd_cyc, wr_cyc, both_cyc = 0, order_bad;
   logic [27:0]  last_rd_addr, last_wr_addr;
   logic [127:0] last_wr_data;

   // Reference model: CPU-visible bytes, backing-store bytes, line shadow
   logic [7:0]   ref_b [logic [31:0]];
   logic [7:0]   bk_b  [logic [31:0]];
   bit           sh_valid [8];
   bit           sh_dirty [8];
   logic [24:0]  sh_tag   [8];
   int           n_hit = 0, n_miss = 0;
   logic [31:0]  m_rd;
   int           m_st;
   bit           m_wb;
   logic [27:0]  m_wa;
   logic [127:0] m_wd;

   function automatic logic [31:0] init_word(input logic [27:0] b, input int w);
      return (32'(b) * 32'h9E37_79B1) ^ (32'h0101_0101 * 32'(w + 1));
   endfunction

   function automatic logic [127:0] blk_init(input logic [27:0] b);
      return {init_word(b, 3), init_word(b, 2), init_word(b, 1), init_word(b, 0)};
   endfunction

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      logic [31:0] w;
      w = init_word(a[31:4], int'(a[3:2]));
      return w[{a[1:0], 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] vbyte(input logic [31:0] a);
      if (ref_b.exists(a)) return ref_b[a];
      return init_byte(a);
   endfunction

   function automatic logic [127:0] view_block(input logic [27:0] b);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = vbyte({b, 4'(i)});
      return r;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] hb, wb;
      hb = a & ~32'd1;
      wb = a & ~32'd3;
      case (f3)
         3'b000:  return {{24{vbyte(a)[7]}}, vbyte(a)};
         3'b001:  return {{16{vbyte(hb + 1)[7]}}, vbyte(hb + 1), vbyte(hb)};
         3'b010:  return {vbyte(wb + 3), vbyte(wb + 2), vbyte(wb + 1), vbyte(wb)};
         3'b100:  return {24'h0, vbyte(a)};
         3'b101:  return {16'h0, vbyte(hb + 1), vbyte(hb)};
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Responder: holds busy for 'stretch' cycles of each request phase, then serves/accepts
   always @(negedge CLK) begin
      logic [1:0] kind;
      kind = {MAIN_MEM_READ, MAIN_MEM_WRITE};
      if (kind == 2'b00) begin
         kind_cnt = 0;
         MAIN_MEM_BUSY_WAIT = 1'b0;
      end else begin
         if (kind != prev_kind) kind_cnt = 0;
         MAIN_MEM_BUSY_WAIT = (kind_cnt < stretch);
         kind_cnt++;
      end
      prev_kind = kind;
      if (MAIN_MEM_READ) begin
         rd_cyc++;
         last_rd_addr = MAIN_MEM_ADDRESS;
         MAIN_MEM_READ_DATA = mm.exists(MAIN_MEM_ADDRESS) ? mm[MAIN_MEM_ADDRESS]
                                                           : blk_init(MAIN_MEM_ADDRESS);
      end
      if (MAIN_MEM_WRITE) begin
         if (rd_cyc > 0) order_bad++;
         wr_cyc++;
         last_wr_addr = MAIN_MEM_ADDRESS;
         last_wr_data = MAIN_MEM_WRITE_DATA;
         mm[MAIN_MEM_ADDRESS] = MAIN_MEM_WRITE_DATA;
      end
      if (MAIN_MEM_READ && MAIN_MEM_WRITE) both_cyc++;
   end

   task automatic model_op(input logic [3:0] mr, input logic [2:0] mw,
                           input logic [31:0] a, input logic [31:0] wd);
      logic [2:0]  idx;
      logic [24:0] tag;
      logic [31:0] base;
      int          phase;
      idx   = a[6:4];
      tag   = a[31:7];
      phase = (stretch + 1 > 2) ? stretch + 1 : 2;
      m_rd  = 32'h0;
      m_st  = 0;
      m_wb  = 1'b0;
      if ((mr[3] || mw[2]) && !(sh_valid[idx] && sh_tag[idx] == tag)) begin
         m_st = phase + 2;
         if (sh_valid[idx] && sh_dirty[idx]) begin
            m_wb = 1'b1;
            m_wa = {sh_tag[idx], idx};
            m_wd = view_block(m_wa);
            m_st += phase;
            for (int i = 0; i < 16; i++) bk_b[{m_wa, 4'(i)}] = m_wd[i*8 +: 8];
         end
         sh_valid[idx] = 1'b1;
         sh_tag[idx]   = tag;
         sh_dirty[idx] = 1'b0;
         n_miss++;
      end else if (mr[3] || mw[2]) begin
         n_hit++;
      end
      if (mw[2]) begin
         case (mw[1:0])
            2'b00: ref_b[a] = wd[7:0];
            2'b01: begin
               base = a & ~32'd1;
               ref_b[base] = wd[7:0];
               ref_b[base + 1] = wd[15:8];
            end
            default: begin
               base = a & ~32'd3;
               for (int i = 0; i < 4; i++) ref_b[base + 32'(i)] = wd[i*8 +: 8];
            end
         endcase
         sh_dirty[idx] = 1'b1;
      end else if (mr[3]) begin
         m_rd = ref_load(mr[2:0], a);
      end
   endtask

   // Entered just after a rising edge; returns just after the edge that ends the access
   task automatic dut_access(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output int stalls);
      rd_cyc = 0;
      wr_cyc = 0;
      order_bad = 0;
      memRead = mr;
      memWrite = mw;
      ADDRESS = a;
      WRITE_DATA = wd;
      stalls = 0;
      @(negedge CLK);
      while (BUSY_WAIT !== 1'b0 && stalls < 300) begin
         stalls++;
         @(negedge CLK);
      end
      if (stalls >= 300) begin
         n_cmp++;
         n_bad++;
         $display("FAIL busy_timeout: addr %h still stalled after %0d cycles", a, stalls);
      end
      rd = READ_DATA;
      @(posedge CLK);
      #1;
      memRead = '0;
      memWrite = '0;
   endtask

   task automatic run_op(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output int st);
      model_op(mr, mw, a, wd);
      dut_access(mr, mw, a, wd, rd, st);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      memRead = '0;
      memWrite = '0;
      ADDRESS = '0;
      WRITE_DATA = '0;
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_busy", 128'(BUSY_WAIT), 128'd0);
      chk("rst_mm_read", 128'(MAIN_MEM_READ), 128'd0);
      chk("rst_mm_write", 128'(MAIN_MEM_WRITE), 128'd0);
      chk("rst_mm_addr", 128'(MAIN_MEM_ADDRESS), 128'd0);
      chk("rst_mm_wdata", MAIN_MEM_WRITE_DATA, 128'd0);
      chk("rst_read_data", 128'(READ_DATA), 128'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      ref_b = bk_b;
      for (int i = 0; i < 8; i++) begin
         sh_valid[i] = 1'b0;
         sh_dirty[i] = 1'b0;
      end
      n_hit = 0;
      n_miss = 0;
   endtask

   function automatic vec_t mk(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int st);
      vec_t v;
      v.mr = mr; v.mw = mw; v.a = a; v.wd = wd; v.rd = rd; v.st = st;
      return v;
   endfunction

   initial begin
      vec_t        tbl[$];
      logic [31:0] rd, w20;
      int          st, k;
      logic [3:0]  mr;
      logic [2:0]  mw;
      int          f3s[5] = '{0, 1, 2, 4, 5};

      do_reset();

      // Cold miss: refill only, fixed latency, then hit data
      run_op(4'b1010, 3'b000, 32'h10, 32'h0, rd, st);
      chk("cold_stalls", 128'(st), 128'd4);
      chk("cold_rd_addr", 128'(last_rd_addr), 128'h1);
      chk("cold_rd_cycles", 128'(rd_cyc), 128'd2);
      chk("cold_no_write", 128'(wr_cyc), 128'd0);
      chk("cold_data", 128'(rd), 128'(init_word(28'h1, 0)));

      w20 = init_word(28'h2, 0);
      tbl.push_back(mk(4'b1010, 3'b000, 32'h10, 32'h0, init_word(28'h1, 0), 0));
      tbl.push_back(mk(4'b1010, 3'b000, 32'h00, 32'h0, init_word(28'h0, 0), 4));
      tbl.push_back(mk(4'b0000, 3'b110, 32'h0C, 32'h0000_00AA, 32'h0, 0));
      tbl.push_back(mk(4'b1010, 3'b000, 32'h0C, 32'h0, 32'h0000_00AA, 0));
      tbl.push_back(mk(4'b1100, 3'b000, 32'h0C, 32'h0, 32'h0000_00AA, 0));
      tbl.push_back(mk(4'b1000, 3'b000, 32'h0C, 32'h0, 32'hFFFF_FFAA, 0));
      tbl.push_back(mk(4'b1100, 3'b000, 32'h0D, 32'h0, 32'h0, 0));
      tbl.push_back(mk(4'b1010, 3'b000, 32'h20, 32'h0, w20, 4));
      tbl.push_back(mk(4'b0000, 3'b101, 32'h22, 32'h0000_8001, 32'h0, 0));
      tbl.push_back(mk(4'b1001, 3'b000, 32'h22, 32'h0, 32'hFFFF_8001, 0));
      tbl.push_back(mk(4'b1101, 3'b000, 32'h22, 32'h0, 32'h0000_8001, 0));
      tbl.push_back(mk(4'b1100, 3'b000, 32'h21, 32'h0, {24'h0, init_byte(32'h21)}, 0));
      tbl.push_back(mk(4'b1100, 3'b000, 32'h24, 32'h0, {24'h0, init_byte(32'h24)}, 0));
      tbl.push_back(mk(4'b1001, 3'b000, 32'h23, 32'h0, 32'hFFFF_8001, 0));
      tbl.push_back(mk(4'b1010, 3'b000, 32'h23, 32'h0, {16'h8001, w20[15:0]}, 0));
      tbl.push_back(mk(4'b1011, 3'b000, 32'h20, 32'h0, 32'h0, 0));
      tbl.push_back(mk(4'b0000, 3'b100, 32'h0E, 32'h0000_007F, 32'h0, 0));
      tbl.push_back(mk(4'b1010, 3'b000, 32'h0C, 32'h0, 32'h007F_00AA, 0));
      foreach (tbl[i]) begin
         run_op(tbl[i].mr, tbl[i].mw, tbl[i].a, tbl[i].wd, rd, st);
         chk($sformatf("vec%0d_rd", i), 128'(rd), 128'(tbl[i].rd));
         chk($sformatf("vec%0d_stalls", i), 128'(st), 128'(tbl[i].st));
         if (tbl[i].st == 0) chk($sformatf("vec%0d_traffic", i), 128'(rd_cyc + wr_cyc), 128'd0);
      end

      // Dirty victim at index 1 evicted by tag 1
      run_op(4'b0000, 3'b110, 32'h14, 32'hDEAD_BEEF, rd, st);
      chk("dirty_store_stalls", 128'(st), 128'd0);
      run_op(4'b1010, 3'b000, 32'h90, 32'h0, rd, st);
      chk("evict_stalls", 128'(st), 128'd6);
      chk("evict_wb_addr", 128'(last_wr_addr), 128'h1);
      chk("evict_wb_data", last_wr_data,
          {init_word(28'h1, 3), init_word(28'h1, 2), 32'hDEAD_BEEF, init_word(28'h1, 0)});
      chk("evict_wb_before_rd", 128'(order_bad), 128'd0);
      chk("evict_rd_addr", 128'(last_rd_addr), 128'h9);
      chk("evict_data", 128'(rd), 128'(init_word(28'h9, 0)));

      // Main memory holds busy for 5 cycles of the refill
      stretch = 5;
      run_op(4'b1010, 3'b000, 32'h1B0, 32'h0, rd, st);
      chk("stretch_stalls", 128'(st), 128'd8);
      chk("stretch_rd_cycles", 128'(rd_cyc), 128'd6);
      chk("stretch_data", 128'(rd), 128'(init_word(28'h1B, 0)));
      stretch = 0;

      // Load and store together: store wins
      run_op(4'b1010, 3'b110, 32'h0C, 32'h1234_5678, rd, st);
      chk("both_rd_zero", 128'(rd), 128'd0);
      chk("both_stalls", 128'(st), 128'd0);
      run_op(4'b1010, 3'b000, 32'h0C, 32'h0, rd, st);
      chk("both_store_applied", 128'(rd), 128'h1234_5678);

      // Reset in the middle of a refill
      stretch = 5;
      memRead = 4'b1010;
      ADDRESS = 32'h2C0;
      k = 0;
      @(negedge CLK);
      while (MAIN_MEM_READ !== 1'b1 && k < 40) begin
         k++;
         @(negedge CLK);
      end
      chk("midfill_read", 128'(MAIN_MEM_READ), 128'd1);
      chk("midfill_addr", 128'(MAIN_MEM_ADDRESS), 128'h2C);
      @(posedge CLK);
      #1;
      stretch = 0;
      do_reset();
      run_op(4'b1010, 3'b000, 32'h2C0, 32'h0, rd, st);
      chk("post_rst_remiss", 128'(st), 128'd4);
      run_op(4'b1010, 3'b000, 32'h0C, 32'h0, rd, st);
      chk("post_rst_dirty_lost", 128'(rd), 128'(init_word(28'h0, 3)));
      run_op(4'b1010, 3'b000, 32'h14, 32'h0, rd, st);
      chk("post_rst_wb_kept", 128'(rd), 128'hDEAD_BEEF);

      // Randomized traffic over 8 tags x 8 indices
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, wd;
         int r;
         r = int'($urandom_range(0, 9));
         a = 32'($urandom_range(0, 1023));
         wd = $urandom;
         mr = '0;
         mw = '0;
         if (r < 5 || r == 9) mr = {1'b1, 3'(f3s[$urandom_range(0, 4)])};
         if (r >= 5) mw = {1'b1, 2'($urandom_range(0, 2))};
         stretch = int'($urandom_range(0, 3));
         run_op(mr, mw, a, wd, rd, st);
         chk($sformatf("rnd%0d_rd a=%h", n, a), 128'(rd), 128'(m_rd));
         chk($sformatf("rnd%0d_stalls a=%h", n, a), 128'(st), 128'(m_st));
         chk($sformatf("rnd%0d_wb_seen", n), 128'(wr_cyc != 0), 128'(m_wb));
         if (m_wb) begin
            chk($sformatf("rnd%0d_wb_addr", n), 128'(last_wr_addr), 128'(m_wa));
            chk($sformatf("rnd%0d_wb_data", n), last_wr_data, m_wd);
         end
      end
      stretch = 0;
      chk("never_read_and_write", 128'(both_cyc), 128'd0);
`ifdef DCACHE_STATS_EN
      chk("hit_count", 128'(HIT_COUNT), 128'(n_hit));
      chk("miss_count", 128'(MISS_COUNT), 128'(n_miss));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
